mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential scheduler that shares one single-port instruction/data memory between the core's fetch side (PC) and its load/store side (ALU-result address, register write data). It latches one request at a time, drives the memory handshake, returns registered read data with a one-cycle done pulse, and raises a stall so the core holds PC and register writes while any access is outstanding. Data accesses have priority by default. A burst counter keeps fetch from being starved.

## Interface
Parameters:
- DATA_BURST, 4: maximum consecutive data grants while a fetch is waiting; range 1–15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock, sync active-high reset.
- if_req  in  1  fetch request; hold high with if_addr stable until if_done.
- if_addr  in  32  fetch byte address (PC).
- if_done  out  1  one-cycle pulse: fetch completed, if_rdata valid.
- if_rdata  out  32  fetched instruction; holds until the next fetch completes.
- d_req  in  1  data request; hold high with d_we, d_addr, d_wdata, d_be stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables; ignored for loads.
- d_done  out  1  one-cycle pulse: data access completed.
- d_rdata  out  32  load data; unchanged by stores.
- mem_req  out  1  memory request; high from grant until mem_ready is sampled.
- mem_we  out  1  registered copy of the granted access's write flag.
- mem_addr  out  32  registered granted address.
- mem_wdata  out  32  registered store data (0 for fetches).
- mem_be  out  4  registered byte enables (4'b0000 for loads and fetches).
- mem_ready  in  1  memory completes the access in any cycle where it is high and mem_req is high.
- mem_rdata  in  32  read data; valid with mem_ready.
- core_stall  out  1  hold PC and RegWrite.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Evaluate eligible requests. A requester is not eligible in a cycle where its own done is high.
  - d_req only → BUSY_D; if_req only → BUSY_I.
  - Both eligible → BUSY_D, unless burst_cnt == DATA_BURST, then BUSY_I.
  - On grant, latch address, we, wdata and be into the mem_* registers.
- BUSY_x:
  - mem_req = 1.
  - On mem_ready: capture mem_rdata into if_rdata (BUSY_I) or into d_rdata (BUSY_D, load only).
  - Pulse the matching done on the next cycle and return to IDLE.
- burst_cnt, 4 bits:
  - Increments on a data grant while if_req is high.
  - Clears on any fetch grant.
  - Saturates at DATA_BURST.
- core_stall = (if_req & ~if_done) | (d_req & ~d_done).
- Requests are never reordered or merged. A requester dropping req before done is a protocol error; the access still completes and done still pulses.

## Timing
- Reset values:
  - state IDLE; mem_req, mem_we 0; mem_addr, mem_wdata 0; mem_be 0.
  - if_done, d_done 0; if_rdata, d_rdata 0; burst_cnt 0.
- Latency:
  - Request seen in IDLE at cycle N → mem_req high at N+1.
  - mem_ready sampled at cycle M → done and rdata at M+1, state IDLE at M+1.
  - Minimum request-to-done is 3 cycles (N, N+1 ready, N+2 done).
- Back-to-back: the next grant is decided in the done cycle (M+1), with mem_req high at M+2. Throughput is one access per 2 + wait cycles.
- mem_ready high while mem_req is low is ignored.
- Reset mid-access: state returns to IDLE and mem_req is 0 from the next cycle. The outstanding access is abandoned, no done pulses, and the memory must tolerate a dropped request.
- if_req and d_req rising in the same cycle as a done: only the non-done requester is eligible.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, BUSY_I, BUSY_D);
  - requester id constants REQ_I and REQ_D;
  - function pick_grant(if_ok, d_ok, burst_full) returning the requester id.
- Single module. No sub-module is natural; the burst counter stays inline.

## Test plan
- Single fetch: if_req = 1, if_addr = 0x100; mem_ready held high → mem_addr = 0x100 at N+1, if_done at N+2, if_rdata = mem_rdata (0x00500093).
- Store with waits: d_we = 1, d_addr = 0x2004, d_wdata = 0xDEADBEEF, d_be = 4'b0011; mem_ready high only on the 3rd BUSY cycle → mem_be = 4'b0011, d_done at N+4, d_rdata unchanged.
- Conflict: both reqs high in IDLE → data granted first, then fetch granted at the done cycle; core_stall high throughout until if_done.
- Starvation with DATA_BURST = 2: if_req held high with continuous data requests → grant order D, D, I, D, D, I.
- Reset mid-access: reset for one cycle during BUSY_D → mem_req 0 next cycle, no d_done, burst_cnt 0, all outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state encoding,
// requester ids and the grant-selection rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_I = 1'b0;
  localparam req_id_t REQ_D = 1'b1;

  // Data wins by default; fetch wins a collision once the data burst limit
  // has been reached. Only meaningful when at least one requester is eligible.
  function automatic req_id_t pick_grant(input logic if_ok,
                                         input logic d_ok,
                                         input logic burst_full);
    if (d_ok && !(if_ok && burst_full)) begin
      pick_grant = REQ_D;
    end else begin
      pick_grant = REQ_I;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side signals of the memory arbiter.
//
// Handshake semantics (request/done and request/ready):
//   - A core requester raises if_req / d_req and holds it, together with its
//     address / write flag / data / byte enables, stable until the matching
//     done pulses for exactly one cycle. In the done cycle the requester may
//     drop the request or present a new one; a request presented in its own
//     done cycle is not considered until the following cycle.
//   - The arbiter holds mem_req high with mem_we/mem_addr/mem_wdata/mem_be
//     stable; the access completes on the first rising edge where both
//     mem_req and mem_ready are high, with mem_rdata valid in that cycle.
//     mem_ready while mem_req is low has no effect.
interface mem_arbiter_if;
  // fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  // load/store side
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_done;
  logic [31:0] d_rdata;
  // memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  // pipeline control
  logic        core_stall;

  // arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ready, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, core_stall
  );

  // core + memory view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ready, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, core_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One access in flight at a time; done pulses one cycle after the memory
// accepts; a burst counter bounds how long a waiting fetch can be passed over.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output state_t        o_dbg_state,
  output logic [3:0]    o_dbg_burst_cnt
);

  localparam logic [3:0] BURST_MAX = 4'(DATA_BURST);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        r_if_done;
  logic        r_d_done;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic [3:0]  r_burst_cnt;

  logic        w_if_ok;
  logic        w_d_ok;
  logic        w_burst_full;
  req_id_t     w_pick;
  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_fire_i;
  logic        w_fire_d;

  // A requester whose done is showing this cycle is not eligible yet, so a
  // stale request cannot be granted a second time.
  assign w_if_ok      = bus.if_req & ~r_if_done;
  assign w_d_ok       = bus.d_req  & ~r_d_done;
  assign w_burst_full = (r_burst_cnt == BURST_MAX);
  assign w_pick       = pick_grant(w_if_ok, w_d_ok, w_burst_full);

  // Access completion: memory ready while the request is being presented.
  assign w_fire_i = (r_state == BUSY_I) & bus.mem_ready;
  assign w_fire_d = (r_state == BUSY_D) & bus.mem_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_if_ok || w_d_ok) begin
          if (w_pick == REQ_D) begin
            w_grant_d   = 1'b1;
            w_state_nxt = BUSY_D;
          end else begin
            w_grant_i   = 1'b1;
            w_state_nxt = BUSY_I;
          end
        end
      end
      BUSY_I: begin
        if (bus.mem_ready) begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch the granted access into the memory-side registers; they hold
  // their value until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'b0000;
    end else if (w_grant_d) begin
      r_mem_we    <= bus.d_we;
      r_mem_addr  <= bus.d_addr;
      r_mem_wdata <= bus.d_wdata;
      r_mem_be    <= bus.d_we ? bus.d_be : 4'b0000;
    end else if (w_grant_i) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= bus.if_addr;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'b0000;
    end
  end

  // Completion: one-cycle done pulses and registered read data.
  // Stores leave d_rdata untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_if_done <= w_fire_i;
      r_d_done  <= w_fire_d;
      if (w_fire_i) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_fire_d && !r_mem_we) begin
        r_d_rdata <= bus.mem_rdata;
      end
    end
  end

  // Burst counter: counts data grants taken while a fetch is asking,
  // saturating at the limit; any fetch grant starts a fresh burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst_cnt <= 4'd0;
    end else if (w_grant_i) begin
      r_burst_cnt <= 4'd0;
    end else if (w_grant_d && bus.if_req && !w_burst_full) begin
      r_burst_cnt <= r_burst_cnt + 4'd1;
    end
  end

  assign bus.mem_req    = (r_state != IDLE);
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_be     = r_mem_be;
  assign bus.if_done    = r_if_done;
  assign bus.if_rdata   = r_if_rdata;
  assign bus.d_done     = r_d_done;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.core_stall = (bus.if_req & ~r_if_done) | (bus.d_req & ~r_d_done);

  assign o_dbg_state     = r_state;
  assign o_dbg_burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int B = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  state_t     dbg_state;
  logic [3:0] dbg_cnt;

  mem_arbiter #(.DATA_BURST(B)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .o_dbg_state     (dbg_state),
    .o_dbg_burst_cnt (dbg_cnt)
  );

  // ---------------- stimulus variables ----------------
  logic        t_rst;
  logic        t_if_req;
  logic [31:0] t_if_addr;
  logic        t_d_req;
  logic        t_d_we;
  logic [31:0] t_d_addr;
  logic [31:0] t_d_wdata;
  logic [3:0]  t_d_be;
  logic        t_ready;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];    // expected grant order
  logic [31:0] grant_q[$];  // observed grant order
  logic        prev_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] v;
    v = mem_rd(a);
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
    mem[a] = v;
  endtask

  // ---------------- reference model ----------------
  // m_own: which access is outstanding (0 none, 1 fetch, 2 data).
  int          m_own;
  logic        m_if_done, m_d_done;
  logic [31:0] m_if_rdata, m_d_rdata;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_cnt;

  task automatic model_reset();
    m_own = 0; m_if_done = 0; m_d_done = 0; m_if_rdata = 0; m_d_rdata = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic if_ok, d_ok, nid, ndd;
    if (t_rst) begin
      model_reset();
      return;
    end
    nid = (m_own == 1) && t_ready;
    ndd = (m_own == 2) && t_ready;
    if (m_own != 0) begin
      if (t_ready) begin
        if (m_own == 1) m_if_rdata = mem_rd(m_addr);
        else if (!m_we) m_d_rdata = mem_rd(m_addr);
        else mem_wr(m_addr, m_wdata, m_be);
        m_own = 0;
      end
    end else begin
      if_ok = t_if_req && !m_if_done;
      d_ok  = t_d_req && !m_d_done;
      if (d_ok && !(if_ok && m_cnt == B)) begin
        m_own = 2; m_we = t_d_we; m_addr = t_d_addr; m_wdata = t_d_wdata;
        m_be = t_d_we ? t_d_be : 4'b0000;
        if (t_if_req && m_cnt < B) m_cnt++;
      end else if (if_ok) begin
        m_own = 1; m_we = 0; m_addr = t_if_addr; m_wdata = 0; m_be = 0; m_cnt = 0;
      end
    end
    m_if_done = nid;
    m_d_done  = ndd;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive one cycle of inputs, check the combinational
  // stall, advance the model at the edge, then check registered outputs.
  task automatic step();
    reset         = t_rst;
    bus.if_req    = t_if_req;
    bus.if_addr   = t_if_addr;
    bus.d_req     = t_d_req;
    bus.d_we      = t_d_we;
    bus.d_addr    = t_d_addr;
    bus.d_wdata   = t_d_wdata;
    bus.d_be      = t_d_be;
    bus.mem_ready = t_ready;
    bus.mem_rdata = t_ready ? mem_rd(bus.mem_addr) : $urandom();
    #1;
    check("core_stall", 32'(bus.core_stall),
          32'((t_if_req & ~m_if_done) | (t_d_req & ~m_d_done)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("mem_req",   32'(bus.mem_req),   32'(m_own != 0));
    check("mem_we",    32'(bus.mem_we),    32'(m_we));
    check("mem_addr",  bus.mem_addr,       m_addr);
    check("mem_wdata", bus.mem_wdata,      m_wdata);
    check("mem_be",    32'(bus.mem_be),    32'(m_be));
    check("if_done",   32'(bus.if_done),   32'(m_if_done));
    check("d_done",    32'(bus.d_done),    32'(m_d_done));
    check("if_rdata",  bus.if_rdata,       m_if_rdata);
    check("d_rdata",   bus.d_rdata,        m_d_rdata);
    check("burst_cnt", 32'(dbg_cnt),       32'(m_cnt));
    if (bus.mem_req && !prev_req) grant_q.push_back(32'(dbg_state));
    prev_req = bus.mem_req;
  endtask

  task automatic new_fetch();
    t_if_req  = 1'b1;
    t_if_addr = 32'h100 + 32'($urandom_range(63, 0)) * 4;
  endtask

  task automatic new_data();
    t_d_req   = 1'b1;
    t_d_we    = 1'($urandom_range(1, 0));
    t_d_addr  = 32'h2000 + 32'($urandom_range(15, 0)) * 4;
    t_d_wdata = $urandom();
    t_d_be    = 4'($urandom_range(15, 0));
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    t_if_req = 0; t_d_req = 0; t_ready = 1; t_rst = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (m_own == 0 && !m_if_done && !m_d_done) begin
        ok = 1;
        break;
      end
    end
    check("drain_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    t_rst = 1; t_if_req = 0; t_d_req = 0; t_ready = 0;
    step();
    step();
    t_rst = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] v;
    bit          ok;

    t_rst = 1; t_if_req = 0; t_if_addr = 0; t_d_req = 0; t_d_we = 0;
    t_d_addr = 0; t_d_wdata = 0; t_d_be = 0; t_ready = 0;
    model_reset();
    @(negedge clk);

    // reset values
    do_reset();
    check("rst_mem_req",  32'(bus.mem_req),  32'd0);
    check("rst_mem_addr", bus.mem_addr,      32'd0);
    check("rst_if_rdata", bus.if_rdata,      32'd0);
    check("rst_d_rdata",  bus.d_rdata,       32'd0);
    check("rst_state",    32'(dbg_state),    32'(IDLE));

    // single fetch, memory always ready
    mem[32'h100] = 32'h00500093;
    t_if_req = 1; t_if_addr = 32'h100; t_ready = 1;
    step();
    check("t1_mem_req",  32'(bus.mem_req), 32'd1);
    check("t1_mem_addr", bus.mem_addr,     32'h100);
    step();
    check("t1_if_done",  32'(bus.if_done), 32'd1);
    check("t1_if_rdata", bus.if_rdata,     32'h00500093);
    t_if_req = 0;
    step();
    check("t1_done_pulse", 32'(bus.if_done), 32'd0);

    // store with two wait cycles, then read it back
    t_d_req = 1; t_d_we = 1; t_d_addr = 32'h2004; t_d_wdata = 32'hDEADBEEF;
    t_d_be = 4'b0011; t_ready = 0;
    step();
    check("t2_mem_be",    32'(bus.mem_be), 32'h3);
    check("t2_mem_wdata", bus.mem_wdata,   32'hDEADBEEF);
    step();
    step();
    check("t2_no_early_done", 32'(bus.d_done), 32'd0);
    t_ready = 1;
    step();
    check("t2_d_done",  32'(bus.d_done), 32'd1);
    check("t2_d_rdata", bus.d_rdata,     32'd0);
    t_d_we = 0;  // load of the same word presented in the done cycle
    step();
    check("t2_reload_ineligible", 32'(bus.mem_req), 32'd0);
    step();
    step();
    v = dflt(32'h2004);
    check("t2_load_merged", bus.d_rdata, {v[31:16], 16'hBEEF});
    t_d_req = 0;
    step();

    // conflict: data first, fetch granted in the data done cycle
    grant_q.delete();
    t_if_req = 1; t_if_addr = 32'h104; t_d_req = 1; t_d_we = 0; t_d_addr = 32'h2008;
    t_ready = 1;
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m_d_done) t_d_req = 0;
      if (m_if_done) begin
        t_if_req = 0;
        ok = 1;
        break;
      end
    end
    check("t3_timeout", 32'(ok), 32'd1);
    check("t3_ngrants", 32'(grant_q.size()), 32'd2);
    if (grant_q.size() == 2) begin
      check("t3_first",  grant_q[0], 32'(BUSY_D));
      check("t3_second", grant_q[1], 32'(BUSY_I));
    end
    drain();

    // reset in the middle of a data access
    t_if_req = 1; t_if_addr = 32'h108; t_d_req = 1; t_d_we = 0; t_d_addr = 32'h200C;
    t_ready = 0;
    step();
    check("t5_cnt_pre", 32'(dbg_cnt), 32'd1);
    step();
    t_rst = 1;
    step();
    t_rst = 0;
    check("t5_mem_req",  32'(bus.mem_req),  32'd0);
    check("t5_d_done",   32'(bus.d_done),   32'd0);
    check("t5_cnt",      32'(dbg_cnt),      32'd0);
    check("t5_mem_addr", bus.mem_addr,      32'd0);
    check("t5_state",    32'(dbg_state),    32'(IDLE));
    t_if_req = 0; t_d_req = 0; t_ready = 1;
    step();
    check("t5_no_done", 32'(bus.d_done), 32'd0);
    step();

    // burst limit: fetch steps aside during each data done cycle so both
    // requesters collide in IDLE on the following cycle
    do_reset();
    grant_q.delete();
    exp_q = '{32'(BUSY_D), 32'(BUSY_D), 32'(BUSY_I), 32'(BUSY_D), 32'(BUSY_D), 32'(BUSY_I)};
    t_ready = 1; t_if_addr = 32'h110;
    new_data();
    for (int i = 0; i < 60 && grant_q.size() < 6; i++) begin
      if (m_d_done) new_data();
      if (m_if_done) new_fetch();
      t_d_req  = 1;
      t_if_req = !m_d_done;
      step();
    end
    check("t4_ngrants", 32'(grant_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_q.size(); i++) check("t4_order", grant_q[i], exp_q[i]);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (t_if_req) begin
        if (m_if_done) begin
          if ($urandom_range(1, 0) == 1) new_fetch();
          else t_if_req = 0;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        new_fetch();
      end
      if (t_d_req) begin
        if (m_d_done) begin
          if ($urandom_range(1, 0) == 1) new_data();
          else t_d_req = 0;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        new_data();
      end
      t_ready = ($urandom_range(3, 0) != 0);
      t_rst   = ($urandom_range(299, 0) == 0);
      step();
    end
    t_rst = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
